programmable_blinker: RTL and testbench

- Downstream consumer of the light-mode controller's slow_left/slow_right (or fast_left/fast_right) shift strobes.
- Holds a saturating speed index and divides a prescaler tick into a square-wave blink output whose half-period depends on that index.
- Two instances are used: one slow blinker and one fast blinker. Each blink output feeds the output multiplexer on the FLASHSLOW or FLASHFAST select.

---
 rtl/programmable_blinker_pkg.sv | 12 +
 rtl/programmable_blinker_if.sv | 20 ++
 rtl/programmable_blinker_blink_divider.sv | 47 ++++
 rtl/programmable_blinker.sv | 65 ++++++
 tb/tb_programmable_blinker.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/programmable_blinker_pkg.sv
// Shared defaults for the slow and fast blinker instances.
// The fast instance differs only in its base half-period.
package programmable_blinker_pkg;

    localparam int NUM_SPEEDS      = 4;
    localparam int IDX_W           = 2;
    localparam int DEFAULT_IDX     = 1;
    localparam int CNT_W           = 5;
    localparam int SLOW_BASE_HALF  = 2;
    localparam int FAST_BASE_HALF  = 1;

endpackage : programmable_blinker_pkg

// File: rtl/programmable_blinker_if.sv
// Strobe inputs and blink/speed outputs of one programmable blinker.
interface programmable_blinker_if #(
    parameter int IDX_W = programmable_blinker_pkg::IDX_W
);
    logic             tick;
    logic             shift_left;
    logic             shift_right;
    logic             blink;
    logic [IDX_W-1:0] speed_idx;

    modport master (
        output tick, shift_left, shift_right,
        input  blink, speed_idx
    );

    modport slave (
        input  tick, shift_left, shift_right,
        output blink, speed_idx
    );
endinterface : programmable_blinker_if

// File: rtl/programmable_blinker_blink_divider.sv
// Divides the tick strobe by a run-time half-period and toggles blink
// each time half ticks have been counted since the last toggle or clear.
module blink_divider #(
    parameter int CNT_W = programmable_blinker_pkg::CNT_W
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           tick,
    input  logic           clear,
    input  logic [CNT_W:0] half,
    output logic           blink
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             blink_q, blink_d;
    logic [CNT_W:0]   last_cnt;

    assign last_cnt = half - (CNT_W+1)'(1);

    // Comparing with >= also recovers from a count beyond the terminal value.
    always_comb begin
        cnt_d   = cnt_q;
        blink_d = blink_q;
        if (clear) begin
            cnt_d = '0;
        end else if (tick) begin
            if ({1'b0, cnt_q} >= last_cnt) begin
                cnt_d   = '0;
                blink_d = ~blink_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            blink_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            blink_q <= blink_d;
        end
    end

    assign blink = blink_q;

endmodule : blink_divider

// File: rtl/programmable_blinker.sv
// Saturating speed index driven by shift strobes; selects the half-period
// of the blink divider and restarts its count on every effective change.
module programmable_blinker
    import programmable_blinker_pkg::*;
#(
    parameter int NUM_SPEEDS  = programmable_blinker_pkg::NUM_SPEEDS,
    parameter int IDX_W       = programmable_blinker_pkg::IDX_W,
    parameter int DEFAULT_IDX = programmable_blinker_pkg::DEFAULT_IDX,
    parameter int BASE_HALF   = programmable_blinker_pkg::SLOW_BASE_HALF,
    parameter int CNT_W       = programmable_blinker_pkg::CNT_W
) (
    input  logic                   clk,
    input  logic                   reset,
    programmable_blinker_if.slave  bus
);
    localparam logic [IDX_W-1:0] MAX_IDX   = IDX_W'(NUM_SPEEDS - 1);
    localparam logic [IDX_W-1:0] RESET_IDX = IDX_W'(DEFAULT_IDX);
    localparam logic [CNT_W:0]   HALF_MIN  = (CNT_W+1)'(BASE_HALF);

    logic [IDX_W-1:0] speed_idx_q, speed_idx_d;
    logic [IDX_W-1:0] shamt;
    logic [CNT_W:0]   half;
    logic             step_up;
    logic             step_down;
    logic             clear;

    assign step_up   = bus.shift_right & ~bus.shift_left & (speed_idx_q < MAX_IDX);
    assign step_down = bus.shift_left & ~bus.shift_right & (speed_idx_q != '0);
    assign clear     = step_up | step_down;

    always_comb begin
        speed_idx_d = speed_idx_q;
        if (step_up) begin
            speed_idx_d = speed_idx_q + IDX_W'(1);
        end else if (step_down) begin
            speed_idx_d = speed_idx_q - IDX_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            speed_idx_q <= RESET_IDX;
        end else begin
            speed_idx_q <= speed_idx_d;
        end
    end

    // Higher index means a faster blink, so the fastest index uses BASE_HALF.
    assign shamt = MAX_IDX - speed_idx_q;
    assign half  = HALF_MIN << shamt;

    blink_divider #(
        .CNT_W (CNT_W)
    ) u_divider (
        .clk   (clk),
        .reset (reset),
        .tick  (bus.tick),
        .clear (clear),
        .half  (half),
        .blink (bus.blink)
    );

    assign bus.speed_idx = speed_idx_q;

endmodule : programmable_blinker

// File: tb/tb_programmable_blinker.sv
// Randomised and directed checks of programmable_blinker against a tick-counting model.
module tb_programmable_blinker;
    import programmable_blinker_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    int   m_idx;
    int   m_ticks;
    logic m_blink;

    programmable_blinker_if #(.IDX_W(IDX_W)) bus ();

    programmable_blinker dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int exp_half(input int idx);
        int h;
        h = SLOW_BASE_HALF;
        for (int k = idx; k < NUM_SPEEDS - 1; k++) h = h * 2;
        return h;
    endfunction

    task automatic model_reset();
        m_idx   = DEFAULT_IDX;
        m_ticks = 0;
        m_blink = 1'b0;
    endtask

    // Drive one clock cycle of stimulus and advance the model by the same edge.
    task automatic cycle(input logic t, input logic l, input logic r);
        int n;
        bus.tick        = t;
        bus.shift_left  = l;
        bus.shift_right = r;
        @(posedge clk);
        n = m_idx;
        if (r && !l && m_idx < NUM_SPEEDS - 1) n = m_idx + 1;
        if (l && !r && m_idx > 0)              n = m_idx - 1;
        if (n != m_idx) begin
            m_idx   = n;
            m_ticks = 0;
        end else if (t) begin
            m_ticks++;
            if (m_ticks >= exp_half(m_idx)) begin
                m_ticks = 0;
                m_blink = ~m_blink;
            end
        end
        #1;
        bus.tick        = 1'b0;
        bus.shift_left  = 1'b0;
        bus.shift_right = 1'b0;
    endtask

    task automatic test_reset();
        reset           = 1'b1;
        bus.tick        = 1'b0;
        bus.shift_left  = 1'b0;
        bus.shift_right = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (bus.blink !== 1'b0) begin
            errors++;
            $display("FAIL reset_blink: got %b expected 0", bus.blink);
        end
        checks++;
        if (bus.speed_idx !== IDX_W'(DEFAULT_IDX)) begin
            errors++;
            $display("FAIL reset_idx: got %0d expected %0d", bus.speed_idx, DEFAULT_IDX);
        end
        $display("reset: blink=%b speed_idx=%0d", bus.blink, bus.speed_idx);
    endtask

    task automatic test_default_blink();
        for (int i = 1; i <= 16; i++) begin
            cycle(1'b1, 1'b0, 1'b0);
            checks++;
            if (bus.blink !== m_blink) begin
                errors++;
                $display("FAIL default_blink tick %0d: got %b expected %b", i, bus.blink, m_blink);
            end
            if (i == 7 || i == 8 || i == 15 || i == 16) begin
                checks++;
                if (bus.blink !== ((i == 8 || i == 15) ? 1'b1 : 1'b0)) begin
                    errors++;
                    $display("FAIL default_edge tick %0d: got %b", i, bus.blink);
                end
            end
        end
        $display("default_blink: 16 ticks, blink=%b", bus.blink);
    endtask

    task automatic test_shift_right();
        int   want [3] = '{2, 3, 3};
        logic b0;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 1'b1);
            checks++;
            if (bus.speed_idx !== IDX_W'(want[i])) begin
                errors++;
                $display("FAIL shift_right step %0d: got %0d expected %0d", i, bus.speed_idx, want[i]);
            end
            $display("shift_right step %0d: speed_idx=%0d", i, bus.speed_idx);
        end
        b0 = bus.blink;
        cycle(1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.blink !== b0) begin
            errors++;
            $display("FAIL fast_half_early: got %b expected %b", bus.blink, b0);
        end
        cycle(1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.blink !== ~b0) begin
            errors++;
            $display("FAIL fast_half_toggle: got %b expected %b", bus.blink, ~b0);
        end
    endtask

    task automatic test_shift_left();
        int   want [4] = '{2, 1, 0, 0};
        logic b0;
        b0 = bus.blink;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, 1'b0);
            checks++;
            if (bus.speed_idx !== IDX_W'(want[i]) || bus.blink !== b0) begin
                errors++;
                $display("FAIL shift_left step %0d: got idx %0d blink %b expected idx %0d blink %b",
                         i, bus.speed_idx, bus.blink, want[i], b0);
            end
            $display("shift_left step %0d: speed_idx=%0d blink=%b", i, bus.speed_idx, bus.blink);
        end
        for (int i = 1; i <= 16; i++) begin
            cycle(1'b1, 1'b0, 1'b0);
            checks++;
            if (bus.blink !== ((i == 16) ? ~b0 : b0)) begin
                errors++;
                $display("FAIL slow_half tick %0d: got %b", i, bus.blink);
            end
        end
    endtask

    task automatic test_both_strobes();
        logic b0;
        cycle(1'b0, 1'b0, 1'b1);
        repeat (3) cycle(1'b1, 1'b0, 1'b0);
        b0 = bus.blink;
        cycle(1'b1, 1'b1, 1'b1);
        checks++;
        if (bus.speed_idx !== IDX_W'(1)) begin
            errors++;
            $display("FAIL both_idx: got %0d expected 1", bus.speed_idx);
        end
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b1, 1'b0, 1'b0);
            checks++;
            if (bus.blink !== ((i == 4) ? ~b0 : b0)) begin
                errors++;
                $display("FAIL both_count tick %0d: got %b", i, bus.blink);
            end
        end
        $display("both_strobes: speed_idx=%0d blink=%b", bus.speed_idx, bus.blink);
    endtask

    task automatic test_coincident_tick();
        logic b0;
        repeat (7) cycle(1'b1, 1'b0, 1'b0);
        b0 = bus.blink;
        cycle(1'b1, 1'b0, 1'b1);
        checks++;
        if (bus.speed_idx !== IDX_W'(2) || bus.blink !== b0) begin
            errors++;
            $display("FAIL coincident: got idx %0d blink %b expected idx 2 blink %b",
                     bus.speed_idx, bus.blink, b0);
        end
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b1, 1'b0, 1'b0);
            checks++;
            if (bus.blink !== ((i == 4) ? ~b0 : b0)) begin
                errors++;
                $display("FAIL coincident_count tick %0d: got %b", i, bus.blink);
            end
        end
        $display("coincident_tick: speed_idx=%0d blink=%b", bus.speed_idx, bus.blink);
    endtask

    task automatic test_random();
        logic t, l, r;
        for (int i = 0; i < 400; i++) begin
            t = ($urandom_range(0, 1) == 1);
            l = ($urandom_range(0, 9) == 0);
            r = ($urandom_range(0, 9) == 0);
            cycle(t, l, r);
            checks++;
            if (bus.blink !== m_blink || bus.speed_idx !== IDX_W'(m_idx)) begin
                errors++;
                $display("FAIL random cycle %0d: got idx %0d blink %b expected idx %0d blink %b",
                         i, bus.speed_idx, bus.blink, m_idx, m_blink);
            end
        end
        $display("random: 400 cycles, final speed_idx=%0d blink=%b", bus.speed_idx, bus.blink);
    endtask

    task automatic test_async_reset();
        int guard;
        repeat (2) cycle(1'b0, 1'b0, 1'b1);
        guard = 0;
        while (m_blink !== 1'b1 && guard < 64) begin
            cycle(1'b1, 1'b0, 1'b0);
            guard++;
        end
        checks++;
        if (bus.blink !== 1'b1 || bus.speed_idx !== IDX_W'(3)) begin
            errors++;
            $display("FAIL async_setup: got idx %0d blink %b expected idx 3 blink 1",
                     bus.speed_idx, bus.blink);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (bus.blink !== 1'b0 || bus.speed_idx !== IDX_W'(DEFAULT_IDX)) begin
            errors++;
            $display("FAIL async_reset: got idx %0d blink %b expected idx %0d blink 0",
                     bus.speed_idx, bus.blink, DEFAULT_IDX);
        end
        $display("async_reset: speed_idx=%0d blink=%b", bus.speed_idx, bus.blink);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, 1'b0, 1'b0);
            checks++;
            if (bus.blink !== m_blink) begin
                errors++;
                $display("FAIL post_reset tick %0d: got %b expected %b", i, bus.blink, m_blink);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_default_blink();
        test_shift_right();
        test_shift_left();
        test_both_strobes();
        test_coincident_tick();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_programmable_blinker
